wishbone_ctrl_pipelined: RTL and testbench

WISHBONE_CTRL_PIPELINED -- requirements
Module: wishbone_ctrl_pipelined

---
 rtl/wishbone_pkg.sv | 23 ++
 rtl/wb_outstanding_cnt.sv | 31 +++
 rtl/wishbone_ctrl_pipelined.sv | 135 +++++++++++++
 tb/tb_wishbone_ctrl_pipelined.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone request/response types for the pipelined controller.
// Struct field widths follow the localparams below; the controller's width parameters default to them.
package wishbone_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 8;
    localparam int WB_SEL_W = WB_DAT_W / 8;
    // Wide enough for MAX_OUTSTANDING up to 15
    localparam int CNT_W    = 4;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_req_t;

    typedef struct packed {
        logic [WB_DAT_W-1:0] dat;
        logic                err;
    } wb_rsp_t;

endpackage

// File: rtl/wb_outstanding_cnt.sv
// Count of strobes issued on the bus and not yet terminated by ack/err.
// Updates on the clock edge; clr wins over inc/dec, and simultaneous inc+dec leave count unchanged.
module wb_outstanding_cnt
    import wishbone_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc) begin
            count <= count - CNT_W'(1);
        end
    end

    assign full = (count >= CNT_W'(MAX));

endmodule

// File: rtl/wishbone_ctrl_pipelined.sv
// Pipelined Wishbone B4 master: cmd -> stb 1 cycle, ack/err -> rsp_valid 1 cycle; cmd_ready drops on stall or outstanding limit.
// Define WB_CTRL_TIMEOUT_EN to add the bus timeout that abandons a cycle after TIMEOUT_CYCLES quiet cycles.
module wishbone_ctrl_pipelined
    import wishbone_pkg::*;
#(
    parameter int ADR_WIDTH       = WB_ADR_W,
    parameter int DAT_WIDTH       = WB_DAT_W,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [ADR_WIDTH-1:0]   cmd_adr_i,
    input  logic [DAT_WIDTH-1:0]   cmd_dat_i,
    input  logic [DAT_WIDTH/8-1:0] cmd_sel_i,
    output logic                   rsp_valid_o,
    output logic [DAT_WIDTH-1:0]   rsp_dat_o,
    output logic                   rsp_err_o,
    output logic                   timeout_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [ADR_WIDTH-1:0]   wb_adr_o,
    output logic [DAT_WIDTH-1:0]   wb_dat_o,
    output logic [DAT_WIDTH/8-1:0] wb_sel_o,
    input  logic [DAT_WIDTH-1:0]   wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_stall_i
);

    wb_req_t          req_q;
    wb_rsp_t          rsp_q;
    logic             stb_q;
    logic             rsp_vld_q;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W:0]   inflight;
    logic             cnt_full;
    logic             accept;
    logic             issue;
    logic             bus_done;
    logic             rsp_ev;
    logic             tmo_hit;

    assign bus_done = wb_ack_i || wb_err_i;
    // A termination with nothing outstanding is stray and must not produce a response
    assign rsp_ev   = bus_done && (out_cnt != '0);
    assign issue    = stb_q && !wb_stall_i;
    assign inflight = {1'b0, out_cnt} + {{CNT_W{1'b0}}, stb_q};

    assign cmd_ready_o = rst_ni && !tmo_hit && (!stb_q || !wb_stall_i) && !cnt_full &&
                         (inflight < (CNT_W+1)'(MAX_OUTSTANDING));
    assign accept      = cmd_valid_i && cmd_ready_o;

    wb_outstanding_cnt #(
        .MAX (MAX_OUTSTANDING)
    ) u_out_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (issue),
        .dec    (rsp_ev),
        .clr    (tmo_hit),
        .count  (out_cnt),
        .full   (cnt_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= '0;
            stb_q <= 1'b0;
        end else if (tmo_hit) begin
            stb_q <= 1'b0;
        end else if (accept) begin
            req_q <= '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
            stb_q <= 1'b1;
        end else if (issue) begin
            stb_q <= 1'b0;
        end
    end

    // A timeout in the same cycle as a late ack still drops the transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
        end else begin
            rsp_vld_q <= rsp_ev && !tmo_hit;
            if (rsp_ev) begin
                rsp_q <= '{dat: wb_dat_i, err: wb_err_i};
            end
        end
    end

`ifdef WB_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= tmo_hit;
            if (tmo_hit || !wb_cyc_o || bus_done) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    assign timeout_o = tmo_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign wb_stb_o    = stb_q;
    assign wb_cyc_o    = stb_q || (out_cnt != '0);
    assign wb_we_o     = stb_q && req_q.we;
    assign wb_adr_o    = req_q.adr;
    assign wb_dat_o    = req_q.dat;
    assign wb_sel_o    = req_q.sel;
    assign rsp_valid_o = rsp_vld_q;
    assign rsp_dat_o   = rsp_q.dat;
    assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_wishbone_ctrl_pipelined.sv
// Directed and randomized checks of wishbone_ctrl_pipelined against a queue-based bus model.
module tb_wishbone_ctrl_pipelined;

    localparam int MAX = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_dat;
    logic [0:0]  cmd_sel;
    logic        rsp_valid, rsp_err, timeout;
    logic [7:0]  rsp_dat;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [7:0]  wdat;
    logic [0:0]  sel;
    logic [7:0]  rdat;
    logic        ack, err, stall;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  dat;
        logic        sel;
    } req_s;

    req_s        acc_q[$];
    req_s        r;
    int          m_out;
    int          quiet;
    bit          rv, re_exp, exp_stb, exp_rdy, exp_cyc, draining;
    logic [7:0]  rd_exp;

    wishbone_ctrl_pipelined #(
        .ADR_WIDTH       (32),
        .DAT_WIDTH       (8),
        .MAX_OUTSTANDING (MAX),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .timeout_o   (timeout),
        .wb_cyc_o    (cyc),
        .wb_stb_o    (stb),
        .wb_we_o     (we),
        .wb_adr_o    (adr),
        .wb_dat_o    (wdat),
        .wb_sel_o    (sel),
        .wb_dat_i    (rdat),
        .wb_ack_i    (ack),
        .wb_err_i    (err),
        .wb_stall_i  (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2-3 time units after the rising edge
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        ack       = 1'b0;
        err       = 1'b0;
        stall     = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] d, input string tag);
        next();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = a; cmd_dat = 8'h00; cmd_sel = 1'b1;
        #1 check({tag, "_ready"}, cmd_ready, 1);
        next();
        cmd_valid = 1'b0;
        #1;
        check({tag, "_stb"}, stb, 1);
        check({tag, "_adr"}, adr, a);
        check({tag, "_we"}, we, 0);
        check({tag, "_cyc1"}, cyc, 1);
        next();
        ack = 1'b1; rdat = d;
        #1;
        check({tag, "_stb_low"}, stb, 0);
        check({tag, "_cyc2"}, cyc, 1);
        check({tag, "_no_rsp_yet"}, rsp_valid, 0);
        next();
        ack = 1'b0;
        #1;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_dat"}, rsp_dat, d);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_cyc_low"}, cyc, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = 1'b0; rdat = '0;
        #1 rst_n = 1'b0;
        cmd_valid = 1'b1;
        #2;
        check("rst_ready", cmd_ready, 0);
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        next();
        check("rst_ready_clk", cmd_ready, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_we", we, 0);
        check("rst_out_cnt", dut.out_cnt, 0);
        next();
        rst_n = 1'b1;
        cmd_valid = 1'b0;

        // Single read
        do_read(32'h10, 8'hA5, "rd1");

        // Burst of four writes, fifth blocked by the outstanding limit
        for (int i = 0; i < 4; i++) begin
            next();
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h100 + i; cmd_dat = 8'(8'h30 + i); cmd_sel = 1'b1;
            #1 check("burst_ready", cmd_ready, 1);
            if (i > 0) begin
                check("burst_stb", stb, 1);
                check("burst_adr", adr, 32'h100 + i - 1);
                check("burst_we", we, 1);
            end
        end
        next();
        cmd_adr = 32'h200; cmd_dat = 8'h99;
        #1;
        check("burst_stb4", stb, 1);
        check("burst_adr4", adr, 32'h103);
        check("burst_dat4", wdat, 8'h33);
        check("burst_full_ready", cmd_ready, 0);
        next();
        #1;
        check("burst_stb_done", stb, 0);
        check("burst_ready_wait", cmd_ready, 0);
        check("burst_out_cnt", dut.out_cnt, 4);
        next();
        ack = 1'b1; rdat = 8'h11;
        #1 check("burst_ready_at_ack", cmd_ready, 0);
        next();
        ack = 1'b0;
        #1;
        check("burst_rsp", rsp_valid, 1);
        check("burst_rsp_dat", rsp_dat, 8'h11);
        check("burst_ready_after_ack", cmd_ready, 1);
        next();
        cmd_valid = 1'b0; ack = 1'b1;
        #1;
        check("burst_fifth_stb", stb, 1);
        check("burst_fifth_adr", adr, 32'h200);
        repeat (3) next();
        next();
        ack = 1'b0;
        #1;
        check("burst_drain_cyc", cyc, 0);
        check("burst_drain_cnt", dut.out_cnt, 0);

        // Stall holds the first request
        next();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h55; cmd_dat = 8'h77; cmd_sel = 1'b1;
        #1 check("stall_ready0", cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            next();
            cmd_adr = 32'h66; cmd_dat = 8'h88; stall = 1'b1;
            #1;
            check("stall_adr", adr, 32'h55);
            check("stall_dat", wdat, 8'h77);
            check("stall_we", we, 1);
            check("stall_sel", sel, 1);
            check("stall_ready", cmd_ready, 0);
            check("stall_cnt", dut.out_cnt, 0);
        end
        next();
        stall = 1'b0;
        #1;
        check("stall_release_ready", cmd_ready, 1);
        check("stall_release_adr", adr, 32'h55);
        next();
        cmd_valid = 1'b0;
        #1;
        check("stall_cnt1", dut.out_cnt, 1);
        check("stall_adr2", adr, 32'h66);
        check("stall_dat2", wdat, 8'h88);
        next();
        ack = 1'b1;
        #1 check("stall_cnt2", dut.out_cnt, 2);
        next();
        next();
        ack = 1'b0;
        #1;
        check("stall_done_cyc", cyc, 0);
        check("stall_done_cnt", dut.out_cnt, 0);

        // Issue and ack in the same cycle, err on the middle of three reads
        next();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h400;
        next();
        cmd_adr = 32'h401;
        next();
        cmd_adr = 32'h402; ack = 1'b1; rdat = 8'h11;
        #1 check("sim_cnt_a", dut.out_cnt, 1);
        next();
        cmd_valid = 1'b0; ack = 1'b0; err = 1'b1; rdat = 8'h22;
        #1;
        check("sim_cnt_b", dut.out_cnt, 1);
        check("sim_rsp0", rsp_valid, 1);
        check("sim_rsp0_dat", rsp_dat, 8'h11);
        check("sim_rsp0_err", rsp_err, 0);
        check("sim_adr2", adr, 32'h402);
        next();
        err = 1'b0; ack = 1'b1; rdat = 8'h33;
        #1;
        check("sim_cnt_c", dut.out_cnt, 1);
        check("sim_rsp1", rsp_valid, 1);
        check("sim_rsp1_dat", rsp_dat, 8'h22);
        check("sim_rsp1_err", rsp_err, 1);
        next();
        ack = 1'b0;
        #1;
        check("sim_rsp2", rsp_valid, 1);
        check("sim_rsp2_dat", rsp_dat, 8'h33);
        check("sim_rsp2_err", rsp_err, 0);
        check("sim_cyc_low", cyc, 0);
        // Stray ack with nothing outstanding
        next();
        ack = 1'b1;
        #1 check("stray_rsp_a", rsp_valid, 0);
        next();
        ack = 1'b0;
        #1;
        check("stray_rsp_b", rsp_valid, 0);
        check("stray_cnt", dut.out_cnt, 0);

        // Timeout: one strobe cycle, TMO quiet cycles, then the pulse
        next();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h70;
        next();
        cmd_valid = 1'b0;
`ifdef WB_CTRL_TIMEOUT_EN
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) next();
            #1;
            check("tmo_pulse", timeout, (c == 2 + TMO));
            check("tmo_cyc", cyc, (c < 2 + TMO));
            check("tmo_no_rsp", rsp_valid, 0);
        end
        check("tmo_cnt_clear", dut.out_cnt, 0);
`else
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) next();
            #1;
            check("notmo_pulse", timeout, 0);
            check("notmo_cyc", cyc, 1);
        end
        next();
        ack = 1'b1; rdat = 8'h7E;
        next();
        ack = 1'b0;
        #1;
        check("notmo_rsp", rsp_valid, 1);
        check("notmo_rsp_dat", rsp_dat, 8'h7E);
`endif

        // Asynchronous reset with two transfers outstanding
        next();
        cmd_valid = 1'b1; cmd_adr = 32'h300;
        next();
        cmd_adr = 32'h301;
        next();
        cmd_valid = 1'b0;
        next();
        #1 check("rst2_cnt_before", dut.out_cnt, 2);
        #2;
        rst_n = 1'b0; ack = 1'b1;
        #1;
        check("rst2_cyc_async", cyc, 0);
        check("rst2_stb_async", stb, 0);
        check("rst2_ready", cmd_ready, 0);
        check("rst2_cnt", dut.out_cnt, 0);
        next();
        next();
        check("rst2_no_rsp", rsp_valid, 0);
        rst_n = 1'b1; ack = 1'b0;
        next();
        #1;
        check("rst2_after_rsp", rsp_valid, 0);
        check("rst2_after_cyc", cyc, 0);
        do_read(32'h44, 8'h5A, "post_rst");

        // Randomized traffic against the queue model
        m_out = 0; quiet = 0; rv = 1'b0; re_exp = 1'b0; rd_exp = '0;
        for (int n = 0; n < 400; n++) begin
            draining = (n >= 360);
            next();
            cmd_valid = !draining && ($urandom_range(0, 99) < 60);
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_adr   = $urandom;
            cmd_dat   = 8'($urandom);
            cmd_sel   = 1'($urandom);
            stall     = (quiet < 4) && ($urandom_range(0, 3) == 0);
            ack = 1'b0; err = 1'b0;
            if (m_out > 0 && (draining || quiet >= 4 || $urandom_range(0, 99) < 40)) begin
                if ($urandom_range(0, 3) == 0) err = 1'b1;
                else ack = 1'b1;
            end else if (m_out == 0 && $urandom_range(0, 19) == 0) begin
                ack = 1'b1;
            end
            rdat = 8'($urandom);
            #1;
            exp_stb = (acc_q.size() != 0);
            exp_rdy = (!exp_stb || !stall) && (m_out + acc_q.size() < MAX);
            exp_cyc = exp_stb || (m_out != 0);
            check("rnd_ready", cmd_ready, exp_rdy);
            check("rnd_stb", stb, exp_stb);
            check("rnd_cyc", cyc, exp_cyc);
            check("rnd_rsp_valid", rsp_valid, rv);
            if (rv) begin
                check("rnd_rsp_dat", rsp_dat, rd_exp);
                check("rnd_rsp_err", rsp_err, re_exp);
            end
            if (exp_stb) begin
                check("rnd_adr", adr, acc_q[0].adr);
                check("rnd_dat", wdat, acc_q[0].dat);
                check("rnd_sel", sel, acc_q[0].sel);
                check("rnd_we", we, acc_q[0].we);
            end else begin
                check("rnd_we_idle", we, 0);
            end
            rv = (ack || err) && (m_out > 0);
            if (rv) begin
                rd_exp = rdat;
                re_exp = err;
                m_out--;
            end
            if (exp_stb && !stall) begin
                void'(acc_q.pop_front());
                m_out++;
            end
            if (cmd_valid && exp_rdy) begin
                r.we = cmd_we; r.adr = cmd_adr; r.dat = cmd_dat; r.sel = cmd_sel;
                acc_q.push_back(r);
            end
            quiet = (exp_cyc && !(ack || err)) ? quiet + 1 : 0;
        end
        next();
        idle();
        #1 check("rnd_end_cyc", cyc, (m_out != 0) || (acc_q.size() != 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
